// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access.
// Data requests always win; the fetched word is held in a one-entry buffer for the IF stage.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                hold_f,
  input  logic                flush_f,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                ibuf_valid,
  output logic                mem_stall_f,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                mem_stall_all,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err,
  output logic [1:0]          dbgState
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DDONE} stateT;

  stateT              state, nextState;
  logic               grantData, grantFetch;
  logic               timeoutHit, xferDone, fetchDone, dataDone;
  logic               dropFetch;
  logic [CNT_W-1:0]   waitCnt;
  logic [DATA_W-1:0]  rdataEff;

  // Handshake: mem_req rises at grant and holds mem_* stable until the cycle
  // mem_ack is sampled high (or the wait counter expires); mem_ack is ignored
  // while mem_req is low. ibuf_valid / dm_valid tell the pipeline its word is ready.
  assign timeoutHit = mem_req & ~mem_ack & (waitCnt == CNT_W'(TIMEOUT - 1));
  assign xferDone   = mem_req & (mem_ack | timeoutHit);
  assign fetchDone  = (state == FETCH) & xferDone;
  assign dataDone   = (state == DATA) & xferDone;
  assign rdataEff   = mem_ack ? mem_rdata : '0;

  assign mem_stall_f   = if_req & ~ibuf_valid;
  assign mem_stall_all = dm_req & ~dm_valid;
  assign dbgState      = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState  = state;
    grantData  = 1'b0;
    grantFetch = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req) begin
          nextState = DATA;
          grantData = 1'b1;
        end else if (if_req & ~ibuf_valid & ~flush_f) begin
          nextState  = FETCH;
          grantFetch = 1'b1;
        end
      end
      FETCH:   if (xferDone) nextState = IDLE;
      DATA:    if (xferDone) nextState = DDONE;
      DDONE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      waitCnt    <= '0;
      bus_err    <= 1'b0;
      dm_rdata   <= '0;
      dm_valid   <= 1'b0;
      dropFetch  <= 1'b0;
      if_rdata   <= '0;
      ibuf_valid <= 1'b0;
    end else begin
      if (grantData) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else if (grantFetch) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end else if (xferDone) begin
        mem_req <= 1'b0;
      end

      if (grantData | grantFetch)  waitCnt <= '0;
      else if (mem_req & ~mem_ack) waitCnt <= waitCnt + CNT_W'(1);

      if (timeoutHit) bus_err <= 1'b1;

      // Stores complete with zero read data so the W stage never sees stale bus values.
      dm_valid <= dataDone;
      if (dataDone) dm_rdata <= mem_we ? '0 : rdataEff;

      // A redirect while the fetch is outstanding poisons that fetch until its ack.
      if (state == FETCH) begin
        if (xferDone)     dropFetch <= 1'b0;
        else if (flush_f) dropFetch <= 1'b1;
      end

      if (flush_f) begin
        ibuf_valid <= 1'b0;
      end else if (fetchDone & ~dropFetch) begin
        ibuf_valid <= 1'b1;
        if_rdata   <= rdataEff;
      end else if (ibuf_valid & ~hold_f & ~mem_stall_all) begin
        ibuf_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, load, arbitration, flush, timeout and mid-transaction reset.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, hold_f, flush_f;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              ibuf_valid, mem_stall_f;
  logic              dm_req, dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic [BE_W-1:0]   dm_be;
  logic              dm_valid, mem_stall_all;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [BE_W-1:0]   mem_be;
  logic              bus_err;
  logic [1:0]        dbgState;

  int compared   = 0;
  int mismatched = 0;

  logic [ADDR_W-1:0] expAddrQ[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .hold_f(hold_f), .flush_f(flush_f),
    .if_rdata(if_rdata), .ibuf_valid(ibuf_valid), .mem_stall_f(mem_stall_f),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .mem_stall_all(mem_stall_all),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .dbgState(dbgState)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
    compared++; if (mem_addr !== '0) begin mismatched++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    compared++; if (mem_be !== '0) begin mismatched++; $display("FAIL reset_mem_be: got %0h want 0", mem_be); end
    compared++; if (ibuf_valid !== 1'b0) begin mismatched++; $display("FAIL reset_ibuf_valid: got %0h want 0", ibuf_valid); end
    compared++; if (dm_valid !== 1'b0) begin mismatched++; $display("FAIL reset_dm_valid: got %0h want 0", dm_valid); end
    compared++; if (bus_err !== 1'b0) begin mismatched++; $display("FAIL reset_bus_err: got %0h want 0", bus_err); end
    compared++; if (dbgState !== 2'd0) begin mismatched++; $display("FAIL reset_state: got %0d want 0", dbgState); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    compared++; if (mem_stall_f !== 1'b1) begin mismatched++; $display("FAIL fetch_stall_c0: got %0h want 1", mem_stall_f); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL fetch_req_c0: got %0h want 0", mem_req); end
    tick();
    #1;
    compared++; if (mem_req !== 1'b1) begin mismatched++; $display("FAIL fetch_req_c1: got %0h want 1", mem_req); end
    compared++; if (mem_addr !== 32'h100) begin mismatched++; $display("FAIL fetch_addr: got %0h want 100", mem_addr); end
    compared++; if (mem_be !== 4'hF) begin mismatched++; $display("FAIL fetch_be: got %0h want f", mem_be); end
    mem_ack = 1'b1; mem_rdata = 32'h00500093; hold_f = 1'b1;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    compared++; if (ibuf_valid !== 1'b1) begin mismatched++; $display("FAIL fetch_ibuf_valid: got %0h want 1", ibuf_valid); end
    compared++; if (if_rdata !== 32'h00500093) begin mismatched++; $display("FAIL fetch_rdata: got %0h want 00500093", if_rdata); end
    compared++; if (mem_stall_f !== 1'b0) begin mismatched++; $display("FAIL fetch_stall_c2: got %0h want 0", mem_stall_f); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL fetch_req_c2: got %0h want 0", mem_req); end
    tick();
    #1;
    compared++; if (ibuf_valid !== 1'b1) begin mismatched++; $display("FAIL fetch_hold_valid: got %0h want 1", ibuf_valid); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL fetch_no_grant_full: got %0h want 0", mem_req); end
    hold_f = 1'b0;
    tick();
    if_req = 1'b0;
    #1;
    compared++; if (ibuf_valid !== 1'b0) begin mismatched++; $display("FAIL fetch_consumed: got %0h want 0", ibuf_valid); end
    tick();
  endtask

  task automatic test_load_wait();
    int stalls = 0;
    int pulses = 0;
    int reqCyc = 0;
    logic [DATA_W-1:0] got = '0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_be = 4'hF;
    for (int c = 0; c < 12; c++) begin
      mem_ack = 1'b0; mem_rdata = '0;
      if (mem_req) begin
        reqCyc++;
        if (reqCyc == 4) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
      end
      #1;
      if (mem_stall_all) stalls++;
      if (dm_valid) begin pulses++; got = dm_rdata; end
      tick();
      if (pulses != 0) dm_req = 1'b0;
    end
    mem_ack = 1'b0; mem_rdata = '0;
    compared++; if (stalls != 5) begin mismatched++; $display("FAIL load_stall_cycles: got %0d want 5", stalls); end
    compared++; if (pulses != 1) begin mismatched++; $display("FAIL load_valid_pulses: got %0d want 1", pulses); end
    compared++; if (got !== 32'hDEADBEEF) begin mismatched++; $display("FAIL load_rdata: got %0h want deadbeef", got); end
    compared++; if (bus_err !== 1'b0) begin mismatched++; $display("FAIL load_bus_err: got %0h want 0", bus_err); end
    compared++; if (dbgState !== 2'd0) begin mismatched++; $display("FAIL load_end_state: got %0d want 0", dbgState); end
  endtask

  task automatic test_priority();
    int grants = 0;
    int dmCycle = -1;
    int fetchCycle = -1;
    logic [DATA_W-1:0] dmData = 'x;
    logic [ADDR_W-1:0] expAddr;
    expAddrQ = {32'h3000, 32'h104};
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'h12345678; dm_be = 4'b0011;
    if_req = 1'b1; if_addr = 32'h104; hold_f = 1'b1;
    for (int c = 0; c < 8; c++) begin
      mem_ack = mem_req;
      mem_rdata = !mem_req ? 32'h0 : (mem_addr == 32'h104) ? 32'h00A00113 : 32'hFFFFFFFF;
      #1;
      if (mem_req) begin
        grants++;
        compared++;
        if (expAddrQ.size() == 0) begin
          mismatched++; $display("FAIL prio_extra_grant: got addr %0h want none", mem_addr);
        end else begin
          expAddr = expAddrQ.pop_front();
          if (mem_addr !== expAddr) begin mismatched++; $display("FAIL prio_grant_addr: got %0h want %0h", mem_addr, expAddr); end
        end
        if (mem_addr == 32'h3000) begin
          compared++; if (mem_we !== 1'b1) begin mismatched++; $display("FAIL prio_store_we: got %0h want 1", mem_we); end
          compared++; if (mem_wdata !== 32'h12345678) begin mismatched++; $display("FAIL prio_store_wdata: got %0h want 12345678", mem_wdata); end
          compared++; if (mem_be !== 4'b0011) begin mismatched++; $display("FAIL prio_store_be: got %0h want 3", mem_be); end
        end
        if (mem_addr == 32'h104 && fetchCycle < 0) fetchCycle = c;
      end
      if (dm_valid) begin dmCycle = c; dmData = dm_rdata; end
      tick();
      if (dmCycle >= 0) dm_req = 1'b0;
    end
    mem_ack = 1'b0; mem_rdata = '0;
    compared++; if (grants != 2) begin mismatched++; $display("FAIL prio_grant_count: got %0d want 2", grants); end
    compared++; if (dmCycle != 2) begin mismatched++; $display("FAIL prio_dm_valid_cycle: got %0d want 2", dmCycle); end
    compared++; if (dmData !== '0) begin mismatched++; $display("FAIL prio_store_rdata: got %0h want 0", dmData); end
    compared++; if (fetchCycle != 4) begin mismatched++; $display("FAIL prio_fetch_cycle: got %0d want 4", fetchCycle); end
    compared++; if (ibuf_valid !== 1'b1) begin mismatched++; $display("FAIL prio_ibuf_valid: got %0h want 1", ibuf_valid); end
    compared++; if (if_rdata !== 32'h00A00113) begin mismatched++; $display("FAIL prio_if_rdata: got %0h want 00a00113", if_rdata); end
    hold_f = 1'b0; if_req = 1'b0; dm_we = 1'b0;
    tick();
    #1;
    compared++; if (ibuf_valid !== 1'b0) begin mismatched++; $display("FAIL prio_consumed: got %0h want 0", ibuf_valid); end
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h200;
    tick();
    #1;
    compared++; if (mem_addr !== 32'h200) begin mismatched++; $display("FAIL flush_first_addr: got %0h want 200", mem_addr); end
    flush_f = 1'b1; if_addr = 32'h300;
    tick();
    flush_f = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hBAD00000;
    #1;
    compared++; if (mem_req !== 1'b1) begin mismatched++; $display("FAIL flush_req_held: got %0h want 1", mem_req); end
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    compared++; if (ibuf_valid !== 1'b0) begin mismatched++; $display("FAIL flush_dropped: got %0h want 0", ibuf_valid); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL flush_req_drop: got %0h want 0", mem_req); end
    tick();
    #1;
    compared++; if (mem_addr !== 32'h300) begin mismatched++; $display("FAIL flush_new_addr: got %0h want 300", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h00000013;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    compared++; if (if_rdata !== 32'h00000013 || ibuf_valid !== 1'b1) begin mismatched++; $display("FAIL flush_refetch: got %0h/%0h want 13/1", if_rdata, ibuf_valid); end
    if_addr = 32'h304;
    tick();
    tick();
    #1;
    compared++; if (mem_req !== 1'b1 || mem_addr !== 32'h304) begin mismatched++; $display("FAIL flush_next_grant: got %0h/%0h want 1/304", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h11111111; flush_f = 1'b1; if_addr = 32'h400;
    tick();
    mem_ack = 1'b0; mem_rdata = '0; flush_f = 1'b0; if_req = 1'b0;
    #1;
    compared++; if (ibuf_valid !== 1'b0) begin mismatched++; $display("FAIL flush_at_ack: got %0h want 0", ibuf_valid); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL flush_at_ack_req: got %0h want 0", mem_req); end
    tick();
  endtask

  task automatic test_timeout();
    int reqCyc = 0;
    int pulses = 0;
    logic [DATA_W-1:0] got = 'x;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000; dm_be = 4'hF;
    mem_ack = 1'b0; mem_rdata = 32'h55555555;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mem_req) reqCyc++;
      if (dm_valid) begin pulses++; got = dm_rdata; end
      tick();
      if (pulses != 0) dm_req = 1'b0;
    end
    mem_rdata = '0;
    compared++; if (reqCyc != 4) begin mismatched++; $display("FAIL timeout_req_cycles: got %0d want 4", reqCyc); end
    compared++; if (pulses != 1) begin mismatched++; $display("FAIL timeout_valid_pulses: got %0d want 1", pulses); end
    compared++; if (got !== '0) begin mismatched++; $display("FAIL timeout_rdata: got %0h want 0", got); end
    compared++; if (bus_err !== 1'b1) begin mismatched++; $display("FAIL timeout_bus_err: got %0h want 1", bus_err); end
    repeat (3) tick();
    #1;
    compared++; if (bus_err !== 1'b1) begin mismatched++; $display("FAIL timeout_bus_err_sticky: got %0h want 1", bus_err); end
  endtask

  task automatic test_reset_mid();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h5000;
    tick();
    #1;
    compared++; if (dbgState !== 2'd2) begin mismatched++; $display("FAIL rstmid_in_data: got %0d want 2", dbgState); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
    #1;
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL rstmid_mem_req: got %0h want 0", mem_req); end
    compared++; if (dm_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_dm_valid: got %0h want 0", dm_valid); end
    compared++; if (dbgState !== 2'd0) begin mismatched++; $display("FAIL rstmid_state: got %0d want 0", dbgState); end
    compared++; if (bus_err !== 1'b0) begin mismatched++; $display("FAIL rstmid_bus_err: got %0h want 0", bus_err); end
    compared++; if (mem_addr !== '0) begin mismatched++; $display("FAIL rstmid_mem_addr: got %0h want 0", mem_addr); end
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    compared++; if (dm_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_stray_ack_valid: got %0h want 0", dm_valid); end
    compared++; if (dbgState !== 2'd0) begin mismatched++; $display("FAIL rstmid_stray_ack_state: got %0d want 0", dbgState); end
    tick();
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; hold_f = 1'b0; flush_f = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_fetch();
    test_load_wait();
    test_priority();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
